alu_wb_stage: RTL and testbench



---
 rtl/alu_wb_pkg.sv | 18 +
 rtl/alu_wb_fifo.sv | 63 ++++++
 rtl/alu_wb_stage.sv | 127 ++++++++++++
 tb/tb_alu_wb_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU write-back stage.
// Configuration macro ALU_WB_BYPASS_EN is consumed by alu_wb_stage.
package alu_wb_pkg;

    localparam int DEPTH_DEFAULT = 2;
    localparam int WB_AW         = 5;

    // Function-select codes the issue side uses when handing results over
    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [31:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO with full/empty/count; head reads as zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_wb_fifo
    import alu_wb_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEFAULT,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? entry_t'('0) : mem[rd_ptr];

    // Storage needs no reset: emptiness is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: HI/LO, status flags, retire counter and a skid FIFO to the register file.
// Define ALU_WB_BYPASS_EN to present a write-back in the accept cycle when the FIFO is empty.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = WB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    FS,
    input  logic [31:0]   Y_hi,
    input  logic [31:0]   Y_lo,
    input  logic          C,
    input  logic          V,
    input  logic          N,
    input  logic          Z,
    input  logic [AW-1:0] d_addr,
    input  logic          d_en,
    input  logic          hilo_ld,
    input  logic          flag_ld,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [AW-1:0] wb_addr,
    output logic [31:0]   wb_data,
    output logic [31:0]   HI,
    output logic [31:0]   LO,
    output logic          C_q,
    output logic          V_q,
    output logic          N_q,
    output logic          Z_q,
    output logic [31:0]   retired
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } stage_entry_t;

    stage_entry_t  in_entry;
    stage_entry_t  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          c_clean;
    logic          v_clean;
    logic [31:0]   retired_q;

    assign in_entry = '{addr: d_addr, data: Y_lo};
    assign in_ready = (fifo_count < DEPTH_C);
    assign accept   = in_valid & in_ready;
    assign pop      = ~fifo_empty & wb_ready;
    assign retired  = retired_q;

`ifdef ALU_WB_BYPASS_EN
    // An empty FIFO with a ready consumer lets the entry skip storage entirely
    assign bypass = fifo_empty & in_valid & d_en & wb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & d_en & ~bypass & ~fifo_full;

    always_comb begin
        wb_valid = ~fifo_empty;
        wb_addr  = head.addr;
        wb_data  = head.data;
        if (bypass) begin
            wb_valid = 1'b1;
            wb_addr  = d_addr;
            wb_data  = Y_lo;
        end
    end

    alu_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (stage_entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Pass-through ops leave C/V undriven upstream, so they are captured as zero
    assign c_clean = (FS != FS_PASS_S) & C;
    assign v_clean = (FS != FS_PASS_S) & V;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI        <= '0;
            LO        <= '0;
            C_q       <= 1'b0;
            V_q       <= 1'b0;
            N_q       <= 1'b0;
            Z_q       <= 1'b0;
            retired_q <= '0;
        end else if (accept) begin
            if (hilo_ld) begin
                HI <= Y_hi;
                LO <= Y_lo;
            end
            if (flag_ld) begin
                C_q <= c_clean;
                V_q <= v_clean;
                N_q <= N;
                Z_q <= Z;
            end
            retired_q <= retired_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus a randomized run against a queue model.
// Honours ALU_WB_BYPASS_EN when the design is built with it.
module tb_alu_wb_stage;

`ifdef ALU_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  FS;
    logic [31:0] Y_hi, Y_lo;
    logic        C, V, N, Z;
    logic [4:0]  d_addr;
    logic        d_en, hilo_ld, flag_ld;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] HI, LO;
    logic        C_q, V_q, N_q, Z_q;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    alu_wb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .Y_hi(Y_hi), .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z),
        .d_addr(d_addr), .d_en(d_en), .hilo_ld(hilo_ld), .flag_ld(flag_ld),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .HI(HI), .LO(LO), .C_q(C_q), .V_q(V_q), .N_q(N_q), .Z_q(Z_q), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; FS = 0; Y_hi = 0; Y_lo = 0; C = 0; V = 0; N = 0; Z = 0;
        d_addr = 0; d_en = 0; hilo_ld = 0; flag_ld = 0;
    endtask

    task automatic test_reset();
        idle();
        wb_ready = 0;
        reset = 1;
        step(); step();
        reset = 0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        checks++; if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_bus got %h/%h want 0/0", wb_addr, wb_data); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", HI, LO); end
        checks++; if ({C_q, V_q, N_q, Z_q} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {C_q, V_q, N_q, Z_q}); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %h want 0", retired); end
    endtask

    task automatic test_single();
        wb_ready = 1;
        in_valid = 1; d_en = 1; d_addr = 5; Y_lo = 32'h0000_00AB;
        #1;
        checks++; if (wb_valid !== BYPASS) begin errors++; $display("FAIL single_pre_valid got %b want %b", wb_valid, BYPASS); end
        step();
        idle();
        checks++; if (wb_valid !== !BYPASS) begin errors++; $display("FAIL single_valid got %b want %b", wb_valid, !BYPASS); end
        checks++; if (wb_addr !== (BYPASS ? 5'd0 : 5'd5)) begin errors++; $display("FAIL single_addr got %0d want %0d", wb_addr, BYPASS ? 0 : 5); end
        checks++; if (wb_data !== (BYPASS ? 32'd0 : 32'hAB)) begin errors++; $display("FAIL single_data got %h want %h", wb_data, BYPASS ? 32'd0 : 32'hAB); end
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL single_retired got %0d want 1", retired); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_mul();
        in_valid = 1; FS = 5'h1E; hilo_ld = 1; d_en = 0; Y_hi = 32'h1; Y_lo = 32'h8000_0000; d_addr = 7;
        step();
        idle();
        checks++; if (HI !== 32'h1) begin errors++; $display("FAIL mul_hi got %h want 1", HI); end
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL mul_lo got %h want 80000000", LO); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mul_no_wb got %b want 0", wb_valid); end
        checks++; if (retired !== 32'd2) begin errors++; $display("FAIL mul_retired got %0d want 2", retired); end
    endtask

    task automatic test_back_to_back();
        ent_t got[$];
        bit   sent;
        int   budget;
        wb_ready = 0;
        for (int a = 1; a <= 2; a++) begin
            in_valid = 1; d_en = 1; d_addr = 5'(a); Y_lo = 32'(100 + a);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", a, in_ready); end
            step();
        end
        d_addr = 3; Y_lo = 103;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", in_ready); end
        checks++; if (retired !== 32'd4) begin errors++; $display("FAIL b2b_stall_retired got %0d want 4", retired); end
        wb_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_same_cycle_ready got %b want 0", in_ready); end
        sent = 0;
        budget = 0;
        while (got.size() < 3 && budget < 12) begin
            if (in_valid && in_ready) sent = 1;
            if (wb_valid) got.push_back('{wb_addr, wb_data});
            step();
            if (sent) in_valid = 0;
            budget++;
        end
        idle();
        checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_drain_count got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i].addr !== 5'(i + 1) || got[i].data !== 32'(101 + i)) begin
                errors++; $display("FAIL b2b_order%0d got %0d/%0d want %0d/%0d", i, got[i].addr, got[i].data, i + 1, 101 + i);
            end
        end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", wb_valid); end
        checks++; if (retired !== 32'd5) begin errors++; $display("FAIL b2b_retired got %0d want 5", retired); end
    endtask

    task automatic test_flags();
        in_valid = 1; FS = 5'h00; flag_ld = 1; C = 1'bx; V = 1'bx; N = 1; Z = 0;
        step();
        checks++; if ({C_q, V_q, N_q, Z_q} !== 4'b0010) begin errors++; $display("FAIL flags_pass got %b want 0010", {C_q, V_q, N_q, Z_q}); end
        FS = 5'h03; flag_ld = 0; C = 1; V = 1; N = 0; Z = 1;
        step();
        checks++; if ({C_q, V_q, N_q, Z_q} !== 4'b0010) begin errors++; $display("FAIL flags_hold got %b want 0010", {C_q, V_q, N_q, Z_q}); end
        flag_ld = 1;
        step();
        idle();
        checks++; if ({C_q, V_q, N_q, Z_q} !== 4'b1101) begin errors++; $display("FAIL flags_load got %b want 1101", {C_q, V_q, N_q, Z_q}); end
        checks++; if (retired !== 32'd8) begin errors++; $display("FAIL flags_retired got %0d want 8", retired); end
    endtask

    task automatic test_counter();
        force dut.retired_q = 32'hFFFF_FFFF;
        step();
        release dut.retired_q;
        #1;
        checks++; if (retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL counter_preload got %h want ffffffff", retired); end
        in_valid = 1;
        step();
        idle();
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL counter_wrap got %h want 0", retired); end
    endtask

`ifdef ALU_WB_BYPASS_EN
    task automatic test_bypass();
        wb_ready = 1;
        in_valid = 1; d_en = 1; d_addr = 9; Y_lo = 32'hDEAD_0009;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'hDEAD_0009) begin
            errors++; $display("FAIL bypass_same_cycle got %b/%0d/%h want 1/9/dead0009", wb_valid, wb_addr, wb_data);
        end
        step();
        idle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bypass_not_queued got %b want 0", wb_valid); end
    endtask
`endif

    task automatic test_random();
        ent_t        q[$];
        logic [31:0] m_hi, m_lo, m_ret;
        logic [3:0]  m_flags;
        bit          byp, acc, exp_valid;
        ent_t        exp_head;
        idle();
        wb_ready = 0;
        reset = 1;
        step();
        reset = 0;
        step();
        m_hi = 0; m_lo = 0; m_ret = 0; m_flags = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            d_en     = ($urandom % 4) != 0;
            hilo_ld  = ($urandom % 4) == 0;
            flag_ld  = 1'($urandom_range(0, 1));
            FS       = (($urandom % 3) == 0) ? 5'h00 : 5'($urandom);
            {C, V, N, Z} = 4'($urandom);
            d_addr   = 5'($urandom);
            Y_hi     = $urandom;
            Y_lo     = $urandom;
            wb_ready = ($urandom % 3) != 0;
            #1;
            byp       = BYPASS && q.size() == 0 && in_valid && d_en && wb_ready;
            exp_valid = (q.size() != 0) || byp;
            exp_head  = (q.size() != 0) ? q[0] : '{d_addr, Y_lo};
            checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, q.size() < DEPTH); end
            checks++; if (wb_valid !== exp_valid) begin errors++; $display("FAIL rnd_wb_valid cyc %0d got %b want %b", cyc, wb_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (wb_addr !== exp_head.addr || wb_data !== exp_head.data) begin
                    errors++; $display("FAIL rnd_wb_entry cyc %0d got %0d/%h want %0d/%h", cyc, wb_addr, wb_data, exp_head.addr, exp_head.data);
                end
            end
            checks++; if (HI !== m_hi || LO !== m_lo) begin errors++; $display("FAIL rnd_hilo cyc %0d got %h/%h want %h/%h", cyc, HI, LO, m_hi, m_lo); end
            checks++; if ({C_q, V_q, N_q, Z_q} !== m_flags) begin errors++; $display("FAIL rnd_flags cyc %0d got %b want %b", cyc, {C_q, V_q, N_q, Z_q}, m_flags); end
            checks++; if (retired !== m_ret) begin errors++; $display("FAIL rnd_retired cyc %0d got %0d want %0d", cyc, retired, m_ret); end
            acc = in_valid && (q.size() < DEPTH);
            if (q.size() != 0 && wb_ready) void'(q.pop_front());
            if (acc) begin
                if (d_en && !byp) q.push_back('{d_addr, Y_lo});
                if (hilo_ld) begin m_hi = Y_hi; m_lo = Y_lo; end
                if (flag_ld) m_flags = {(FS != 5'h00) && C, (FS != 5'h00) && V, N, Z};
                m_ret = m_ret + 1;
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        wb_ready = 1;
        step(); step(); step();
        wb_ready = 0;
        in_valid = 1; d_en = 1; hilo_ld = 1; Y_hi = 32'h1234_5678;
        for (int a = 1; a <= 2; a++) begin
            d_addr = 5'(a + 10); Y_lo = 32'(a);
            step();
        end
        idle();
        checks++; if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b/%b want 1/0", wb_valid, in_ready); end
        checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mid_hi_loaded got %h want 12345678", HI); end
        #2 reset = 1;
        #1;
        checks++; if (wb_valid !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL mid_async got %b/%h/%h want 0/0/0", wb_valid, HI, LO); end
        step();
        reset = 0;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_wb_valid got %b want 0", wb_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL mid_hilo got %h/%h want 0/0", HI, LO); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL mid_retired got %0d want 0", retired); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_back_to_back();
        test_flags();
        test_counter();
`ifdef ALU_WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
